sc_stream_ctrl: RTL and testbench
=================================

// Module: sc_stream_ctrl
// PURPOSE
//  Sequencer and keystream-combiner directly around the 64-round stream-cipher state block.
//  Drives the state block's reload, 64-round update (load_SC64) and tag-insert (insertSC) strobes.
//  Runs initialisation, then XORs 64-bit data beats with keystream Z under valid/ready flow control.
//  Sits between the message-block interface and the SC state block.
// PARAMETERS
//  INIT_ROUNDS  18  number of 64-round updates in initialisation (18 x 64 = 1152 rounds)
//  TAG_ROUNDS   18  number of 64-round updates after tag insertion (only with SC_TAG_INSERT_EN)
//  CNT_W        5   round-counter width; must hold max(INIT_ROUNDS, TAG_ROUNDS)
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   one-cycle request to begin a new message; ignored unless in IDLE
//  sc_load    out  1   one-cycle pulse; reloads key/Npub into the SC state (wired to the SC block's rst)
//  load_SC64  out  1   advance SC state by 64 rounds this cycle
//  insertSC   out  1   XOR tag into SC state this cycle
//  Z          in   64  keystream from SC block; combinational from the current state
//  din        in   64  input data beat
//  din_valid  in   1   din is valid
//  din_last   in   1   qualifies din as the final beat of the message
//  din_ready  out  1   block accepts din this cycle
//  dout       out  64  din ^ Z, registered
//  dout_valid out  1   dout holds a valid beat
//  dout_ready in   1   downstream accepts dout
//  busy       out  1   high in any state other than IDLE
//  done       out  1   one-cycle pulse when the last beat has been accepted downstream
// BEHAVIOUR
//  Reset: FSM enters IDLE, counter = 0. All outputs are 0, including dout and dout_valid.
//   Reset mid-operation aborts immediately; no further strobes are issued.
//  FSM states: IDLE -> LOAD -> INIT -> [TAG -> TINIT] -> RUN -> DRAIN -> IDLE.
//  IDLE:  on start=1, go to LOAD.
//  LOAD:  sc_load=1 for exactly 1 cycle, then INIT with counter = 0.
//  INIT:  load_SC64=1 every cycle. counter++ each cycle.
//   After INIT_ROUNDS cycles (counter == INIT_ROUNDS-1), go to TAG if enabled, otherwise RUN.
//  TAG:   insertSC=1 for exactly 1 cycle, then TINIT with counter = 0.
//  TINIT: same as INIT, for TAG_ROUNDS cycles, then RUN.
//  RUN:   din_ready = !dout_valid | dout_ready (single-entry output register).
//   Accept when din_valid & din_ready. On the accept cycle:
//    - dout <= din ^ Z; dout_valid <= 1
//    - load_SC64=1 in the same cycle, so every beat consumes a fresh 64-bit Z
//   load_SC64 is never asserted in RUN without an accept; keystream is never reused or skipped.
//   Accepting with din_last=1 latches last_pend and moves to DRAIN.
//  DRAIN: din_ready=0, load_SC64=0. When dout_valid & dout_ready, pulse done=1 and go to IDLE.
//  Output handshake:
//   - dout_valid & !dout_ready holds dout stable
//   - dout_valid clears on dout_ready only if no new accept occurs in that cycle
//   - simultaneous drain and accept keeps dout_valid=1 and updates dout
//  Latency: din to dout is 1 cycle. Throughput is 1 beat per cycle with dout_ready held at 1.
//  Strobes: load_SC64, insertSC and sc_load are mutually exclusive and driven combinationally from state.
//  start is ignored outside IDLE.
//  Counter saturates; it never wraps while in INIT or TINIT.
// CONFIGURATION
//  SC_TAG_INSERT_EN defined:
//   - TAG and TINIT states exist
//   - insertSC pulses once, 1 cycle after INIT ends
//   - RUN is entered INIT_ROUNDS + 1 + TAG_ROUNDS cycles after LOAD
//  SC_TAG_INSERT_EN undefined:
//   - TAG and TINIT are removed
//   - insertSC is tied to 0
//   - RUN is entered INIT_ROUNDS cycles after LOAD
// TESTING
//  T1: rst held 2 cycles, then released -> all outputs 0, busy=0.
//  T2: start pulse (no macro, INIT_ROUNDS=18) -> sc_load high in cycle 1, load_SC64 high in cycles 2..19, din_ready=1 in cycle 20.
//  T3: 4 beats din=64'h0 back-to-back, dout_ready=1 -> dout equals the 4 successive Z values, with load_SC64 high on each accept cycle.
//  T4: dout_ready=0 for 5 cycles with a beat pending -> dout stable, din_ready=0, load_SC64=0.
//      Release -> next beat uses the next Z (golden-model compare).
//  T5: din_last on beat 3 -> DRAIN; done pulses on the dout accept cycle; busy=0 the following cycle.
//      start during RUN is ignored.
//  T6: with SC_TAG_INSERT_EN -> insertSC is high exactly 1 cycle, at cycle 20, then 18 load_SC64 cycles.
//      rst asserted mid-TINIT -> IDLE the next cycle, with no strobes.

Source files
------------

// File: rtl/sc_stream_ctrl.sv
// rtl/sc_stream_ctrl.sv - sequencer and keystream combiner around the 64-round SC state block
//
// Purpose:
//   Steps the stream-cipher state block through reload, initialisation and an
//   optional tag-insert phase. It then XORs 64-bit data beats with keystream Z
//   under valid/ready flow control. Each accepted beat advances the state block
//   by one 64-round step, so no keystream word is ever reused or skipped.
//
// Build option:
//   SC_TAG_INSERT_EN - adds the TAG/TINIT phase. Without it, insertSC is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a new message (taken only when idle)
//   sc_load             one-cycle reload pulse to the SC block
//   load_SC64           advance the SC state by 64 rounds this cycle
//   insertSC            XOR the tag into the SC state this cycle
//   Z                   keystream from the SC block (combinational from its state)
//   din/din_valid/din_last/din_ready   input beat stream
//   dout/dout_valid/dout_ready         registered output beat stream
//   busy                high whenever not idle
//   done                pulse on the cycle the final beat leaves downstream

module sc_stream_ctrl #(
  parameter int unsigned INIT_ROUNDS = 18,
  parameter int unsigned TAG_ROUNDS  = 18,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        sc_load,
  output logic        load_SC64,
  output logic        insertSC,
  input  logic [63:0] Z,
  input  logic [63:0] din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        din_ready,
  output logic [63:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
`ifdef SC_TAG_INSERT_EN
    S_TAG   = 3'd3,
    S_TINIT = 3'd4,
`endif
    S_RUN   = 3'd5,
    S_DRAIN = 3'd6
  } state_e;

  // The counter holds at the largest terminal count rather than wrapping.
  localparam int unsigned      MAX_ROUNDS = (INIT_ROUNDS > TAG_ROUNDS) ? INIT_ROUNDS : TAG_ROUNDS;
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MAX_ROUNDS - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_ROUNDS - 1);
`ifdef SC_TAG_INSERT_EN
  localparam logic [CNT_W-1:0] TAG_LAST   = CNT_W'(TAG_ROUNDS - 1);
`endif

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        dout_q;
  logic               dout_valid_q;
  logic               accept;

  // Single-entry output register: a new beat can enter when the slot is empty
  // or is being emptied in the same cycle.
  assign din_ready = (state_q == S_RUN) && (!dout_valid_q || dout_ready);
  assign accept    = din_ready && din_valid;

  assign sc_load   = (state_q == S_LOAD);
`ifdef SC_TAG_INSERT_EN
  assign load_SC64 = (state_q == S_INIT) || (state_q == S_TINIT) || accept;
  assign insertSC  = (state_q == S_TAG);
`else
  assign load_SC64 = (state_q == S_INIT) || accept;
  assign insertSC  = 1'b0;
`endif

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DRAIN) && dout_valid_q && dout_ready;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_LOAD;
        end
        S_LOAD: begin
          state_q <= S_INIT;
          cnt_q   <= '0;
        end
        S_INIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_q   <= '0;
`ifdef SC_TAG_INSERT_EN
            state_q <= S_TAG;
`else
            state_q <= S_RUN;
`endif
          end else if (cnt_q < CNT_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef SC_TAG_INSERT_EN
        S_TAG: begin
          state_q <= S_TINIT;
          cnt_q   <= '0;
        end
        S_TINIT: begin
          if (cnt_q == TAG_LAST) begin
            cnt_q   <= '0;
            state_q <= S_RUN;
          end else if (cnt_q < CNT_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_RUN: begin
          if (accept && din_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (dout_valid_q && dout_ready) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase

      // A simultaneous drain and accept keeps the slot full with the new beat.
      if (accept) begin
        dout_q       <= din ^ Z;
        dout_valid_q <= 1'b1;
      end else if (dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_stream_ctrl.sv
// tb/tb_sc_stream_ctrl.sv - scoreboard bench for sc_stream_ctrl with an SC keystream stand-in

module tb_sc_stream_ctrl;

  localparam int INIT_ROUNDS = 18;
  localparam int TAG_ROUNDS  = 18;
  localparam int TAGOFF      = 1000;
`ifdef SC_TAG_INSERT_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  // Cycle (counted from the LOAD cycle as 1) in which RUN is first visible.
  localparam int RUN_C   = TAG_EN ? INIT_ROUNDS + TAG_ROUNDS + 3 : INIT_ROUNDS + 2;
  // Number of SC updates applied before the first data beat sees Z.
  localparam int BASE    = TAG_EN ? INIT_ROUNDS + TAGOFF + TAG_ROUNDS : INIT_ROUNDS;
  localparam int ABORT_C = RUN_C - 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sc_load, load_SC64, insertSC;
  logic [63:0] Z;
  logic [63:0] din;
  logic        din_valid, din_last, din_ready;
  logic [63:0] dout;
  logic        dout_valid, dout_ready;
  logic        busy, done;

  sc_stream_ctrl #(
    .INIT_ROUNDS(INIT_ROUNDS),
    .TAG_ROUNDS (TAG_ROUNDS),
    .CNT_W      (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sc_load   (sc_load),
    .load_SC64 (load_SC64),
    .insertSC  (insertSC),
    .Z         (Z),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int done_count = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit mon_en   = 1'b0;
  bit hold_pend = 1'b0;
  logic [63:0] held = '0;
  int unsigned sc_idx = 0;

  typedef struct {
    logic [63:0] data;
    bit          last;
  } exp_t;
  exp_t sb[$];

  // Keystream word seen after i updates of the SC state.
  function automatic logic [63:0] mix(input int unsigned i);
    logic [63:0] x;
    x = {i, ~i} * 64'h9E3779B97F4A7C15;
    x = x ^ (x >> 29);
    x = x * 64'hBF58476D1CE4E5B9;
    return x ^ (x >> 32);
  endfunction

  // Expected {sc_load, load_SC64, insertSC, din_ready, busy} in cycle c of a start sequence.
  function automatic logic [4:0] exp_vec(input int c);
    if (c == 1) return 5'b10001;
    if (c >= 2 && c <= INIT_ROUNDS + 1) return 5'b01001;
    if (TAG_EN && c == INIT_ROUNDS + 2) return 5'b00101;
    if (TAG_EN && c >= INIT_ROUNDS + 3 && c <= INIT_ROUNDS + TAG_ROUNDS + 2) return 5'b01001;
    if (c == RUN_C) return 5'b00011;
    return 5'b00000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // SC block stand-in: a position in an abstract keystream sequence.
  always @(posedge clk) begin
    if (sc_load)        sc_idx <= 0;
    else if (load_SC64) sc_idx <= sc_idx + 1;
    else if (insertSC)  sc_idx <= sc_idx + TAGOFF;
  end
  assign Z = mix(sc_idx);

  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dout_ready = 1'b0;
        1:       dout_ready = 1'b1;
        default: dout_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every downstream transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pend) begin
        chk("hold_valid", 64'(dout_valid), 64'd1);
        chk("hold_data", dout, held);
      end
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_beat: actual=%h required=none", dout);
        end else begin
          chk("dout", dout, sb[0].data);
          chk("done_on_last", 64'(done), 64'(sb[0].last));
          if (sb[0].last) done_count <= done_count + 1;
          void'(sb.pop_front());
        end
      end else begin
        chk("done_idle", 64'(done), 64'd0);
      end
      hold_pend <= dout_valid && !dout_ready;
      held      <= dout;
    end
  end

  task automatic start_msg(input int abort_c);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= RUN_C; c++) begin
      @(negedge clk);
      chk($sformatf("seq_c%0d", c), 64'({sc_load, load_SC64, insertSC, din_ready, busy}), 64'(exp_vec(c)));
      if (c == abort_c) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_next", 64'({sc_load, load_SC64, insertSC, din_ready, busy}), 64'd0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("abort_quiet", 64'({sc_load, load_SC64, insertSC, din_ready, busy, dout_valid}), 64'd0);
        end
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input bit last, input int k);
    bit acc = 1'b0;
    din       = d;
    din_valid = 1'b1;
    din_last  = last;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (din_ready) begin
        chk("load_on_accept", 64'(load_SC64), 64'd1);
        sb.push_back('{d ^ mix(BASE + k), last});
        acc = 1'b1;
      end else begin
        chk("no_load_stall", 64'(load_SC64), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    chk("beat_accepted", 64'(acc), 64'd1);
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_load_idle", 64'(load_SC64), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int prev);
    int t = 0;
    while (done_count == prev && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", 64'(done_count != prev), 64'd1);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int prev;
    int n;
    logic [63:0] d0;
    rst = 1'b1;
    start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    din_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_strobes", 64'({sc_load, load_SC64, insertSC, din_ready, busy, done}), 64'd0);
    chk("reset_dout", dout, 64'd0);
    chk("reset_dout_valid", 64'(dout_valid), 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Zero data back-to-back: dout is the raw keystream sequence.
    rdy_mode = 1;
    prev = done_count;
    start_msg(0);
    for (int k = 0; k < 4; k++) send_beat(64'd0, k == 3, k);
    wait_done(prev);

    // Reset part-way through the initialisation rounds.
    start_msg(ABORT_C);

    // Backpressure with a beat pending, start ignored during RUN, then random traffic.
    prev = done_count;
    start_msg(0);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_beat({$urandom, $urandom}, 1'b0, 0);
    din       = {$urandom, $urandom};
    din_valid = 1'b1;
    d0 = '0;
    for (int s = 0; s < 5; s++) begin
      start = (s == 0);
      @(negedge clk);
      chk("stall_ready", 64'({din_ready, load_SC64, sc_load}), 64'd0);
      chk("stall_busy_valid", 64'({busy, dout_valid}), 64'b11);
      if (s == 0) d0 = dout;
      else chk("stall_dout", dout, d0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rdy_mode = 1;
    send_beat(din, 1'b0, 1);
    rdy_mode = 2;
    n = $urandom_range(6, 12);
    for (int k = 2; k < n; k++) begin
      gap($urandom_range(0, 2));
      send_beat({$urandom, $urandom}, k == n - 1, k);
    end
    wait_done(prev);

    // Short message ending on beat 3 with random backpressure.
    prev = done_count;
    start_msg(0);
    for (int k = 0; k < 3; k++) begin
      gap($urandom_range(0, 1));
      send_beat({$urandom, $urandom}, k == 2, k);
    end
    wait_done(prev);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
